// File: rtl/rdata_return_arbiter.sv
// rdata_return_arbiter: registered read-data return path with priority select, wait states and timeout.
// Optional error statistics counter enabled by defining RDATA_ARB_ERR_STATS_EN.
module rdata_return_arbiter #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_VALUE = 32'hBAD0_BAD0
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           ren,
  input  logic [NUM_SLAVES-1:0]          addr_valid,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_rdata,
  input  logic [NUM_SLAVES-1:0]          slave_rvalid,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           rvalid,
  output logic                           rerror,
  output logic                           busy
`ifdef RDATA_ARB_ERR_STATS_EN
  ,
  input  logic                           err_count_clr,
  output logic [15:0]                    err_count
`endif
);
  localparam int SW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DATA_WIDTH-1:0] ERR_D = DATA_WIDTH'(ERR_VALUE);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] sel_q, sel_d, pick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, sel_data;
  logic rerror_q, rerror_d, sel_valid;
  // Fixed priority: scanning downwards leaves the lowest set index.
  always_comb begin
    pick = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) if (addr_valid[i]) pick = SW'(i);
  end
  assign sel_valid = slave_rvalid[sel_q];
  assign sel_data  = slave_rdata[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rerror_d = rerror_q;
    case (state_q)
      IDLE: if (ren && |addr_valid) begin
        sel_d   = pick;
        cnt_d   = '0;
        state_d = WAIT;
      end else if (ren) begin
        rdata_d  = ERR_D;
        rerror_d = 1'b1;
        state_d  = RESP;
      end
      WAIT: if (sel_valid) begin
        rdata_d  = sel_data;
        rerror_d = 1'b0;
        state_d  = RESP;
      end else if (cnt_q == CNT_LAST) begin
        rdata_d  = ERR_D;
        rerror_d = 1'b1;
        state_d  = RESP;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rerror_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rerror_q <= rerror_d;
    end
  end
  assign rdata  = rdata_q;
  assign rvalid = state_q == RESP;
  assign rerror = rvalid & rerror_q;
  assign busy   = state_q != IDLE;
`ifdef RDATA_ARB_ERR_STATS_EN
  logic [15:0] err_count_q, err_count_d;
  assign err_count_d = err_count_clr ? 16'd0 :
                       (rerror && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) err_count_q <= 16'd0;
    else     err_count_q <= err_count_d;
  end
  assign err_count = err_count_q;
`endif
endmodule
